// File: rtl/serial_adder_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// Handshake: a request is accepted on a rising edge where start=1 and busy=0
// (IDLE or DONE); a, b, cin and sub are captured on that edge. done is a
// one-cycle pulse with s/cout/overflow valid; there is no backpressure.
interface serial_adder_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;

  modport master (output start, a, b, cin, sub,
                  input  busy, done, s, cout, overflow);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, s, cout, overflow);
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock with a registered carry
// between digits; result, carry-out and signed overflow appear with done.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus,
  output logic [1:0]     fsm_state
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic             last;
  logic             carry_into_msb;

  // Operands shift right each RUN cycle, so the current digit is always at the bottom.
  always_comb begin
    dsum           = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};
    acc_next       = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last           = (cnt == CW'(N - 1));
    carry_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
  end

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.s        <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
      cnt          <= '0;
      carry        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? ~bus.cin : bus.cin;
            cnt      <= '0;
            acc      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          acc   <= acc_next;
          carry <= dsum[DIGIT];
          // The counter parks at N-1 in DONE; it is cleared only by the next start.
          if (last) begin
            bus.s        <= acc_next;
            bus.cout     <= dsum[DIGIT];
            bus.overflow <= carry_into_msb ^ dsum[DIGIT];
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three WIDTH=8 instances (DIGIT=1,4,8) share one
// stimulus stream; vectors, random operations and multi-cycle corner cases.
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       start_d = 1'b0;
  logic [7:0] a_d = '0;
  logic [7:0] b_d = '0;
  logic       cin_d = 1'b0;
  logic       sub_d = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // instance 0: DIGIT=1, instance 1: DIGIT=4, instance 2: DIGIT=8
  int         nd[3] = '{8, 2, 1};
  logic       busy_v[3];
  logic       done_v[3];
  logic [7:0] s_v[3];
  logic       cout_v[3];
  logic       ovf_v[3];
  logic [1:0] st_v[3];
  logic [7:0] prev_s[3] = '{8'h00, 8'h00, 8'h00};
  bit         prev_ok[3] = '{1'b1, 1'b1, 1'b1};

  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();
  serial_adder_if #(.WIDTH(8)) bus8 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .fsm_state(st_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .fsm_state(st_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave), .fsm_state(st_v[2]));

  assign bus1.start = start_d;  assign bus4.start = start_d;  assign bus8.start = start_d;
  assign bus1.a = a_d;          assign bus4.a = a_d;          assign bus8.a = a_d;
  assign bus1.b = b_d;          assign bus4.b = b_d;          assign bus8.b = b_d;
  assign bus1.cin = cin_d;      assign bus4.cin = cin_d;      assign bus8.cin = cin_d;
  assign bus1.sub = sub_d;      assign bus4.sub = sub_d;      assign bus8.sub = sub_d;

  assign busy_v[0] = bus1.busy; assign busy_v[1] = bus4.busy; assign busy_v[2] = bus8.busy;
  assign done_v[0] = bus1.done; assign done_v[1] = bus4.done; assign done_v[2] = bus8.done;
  assign s_v[0] = bus1.s;       assign s_v[1] = bus4.s;       assign s_v[2] = bus8.s;
  assign cout_v[0] = bus1.cout; assign cout_v[1] = bus4.cout; assign cout_v[2] = bus8.cout;
  assign ovf_v[0] = bus1.overflow;
  assign ovf_v[1] = bus4.overflow;
  assign ovf_v[2] = bus8.overflow;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                input logic c, input logic sb,
                                output logic [7:0] rs, output logic rc, output logic ro);
    int ua, ub, sa, sbv, sum, ss;
    ua  = int'(x);
    ub  = int'(y);
    sa  = int'($signed(x));
    sbv = int'($signed(y));
    if (!sb) begin
      sum = ua + ub + int'(c);
      ss  = sa + sbv + int'(c);
      rc  = (sum > 255);
    end else begin
      sum = ua - ub - int'(c);
      ss  = sa - sbv - int'(c);
      rc  = (ua >= ub + int'(c));
    end
    rs = 8'(sum);
    ro = (ss > 127) || (ss < -128);
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                        input logic tsub, input logic [7:0] es, input logic ec,
                        input logic eo, input bit repulse);
    @(negedge clk);
    a_d = ta; b_d = tb_v; cin_d = tcin; sub_d = tsub; start_d = 1'b1;
    @(negedge clk);
    if (repulse) begin
      a_d = 8'($urandom); b_d = 8'($urandom); cin_d = ~tcin; sub_d = ~tsub;
    end else begin
      start_d = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) start_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (j < nd[i]) begin
          check($sformatf("busy_run[%0d] j=%0d", i, j), 32'(busy_v[i]), 32'd1);
          check($sformatf("done_early[%0d] j=%0d", i, j), 32'(done_v[i]), 32'd0);
          if (prev_ok[i])
            check($sformatf("s_hold[%0d] j=%0d", i, j), 32'(s_v[i]), 32'(prev_s[i]));
        end else if (j == nd[i]) begin
          check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'd1);
          check($sformatf("busy_done[%0d]", i), 32'(busy_v[i]), 32'd0);
          check($sformatf("s[%0d] %h%s%h c%0d", i, ta, tsub ? "-" : "+", tb_v, tcin),
                32'(s_v[i]), 32'(es));
          check($sformatf("cout[%0d]", i), 32'(cout_v[i]), 32'(ec));
          check($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(eo));
        end else if (j == nd[i] + 1) begin
          check($sformatf("done_drop[%0d]", i), 32'(done_v[i]), 32'd0);
          check($sformatf("idle_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      prev_s[i]  = es;
      prev_ok[i] = 1'b1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_busy[%0d]", tag, i), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s_done[%0d]", tag, i), 32'(done_v[i]), 32'd0);
      check($sformatf("%s_s[%0d]", tag, i), 32'(s_v[i]), 32'd0);
      check($sformatf("%s_cout[%0d]", tag, i), 32'(cout_v[i]), 32'd0);
      check($sformatf("%s_ovf[%0d]", tag, i), 32'(ovf_v[i]), 32'd0);
      check($sformatf("%s_state[%0d]", tag, i), 32'(st_v[i]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rs, ra, rb;
    logic       rc, ro, rci, rsb;
    logic [7:0] hold_a[5];
    logic [7:0] hold_b[5];

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 8'h5B, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].s, vecs[i].cout, vecs[i].ovf, 1'b0);

    // start re-pulsed during RUN with other operands must be ignored
    run_op(8'h3C, 8'h4D, 1'b1, 1'b0, 8'h8A, 1'b0, 1'b1, 1'b1);

    // start held high: the DIGIT=4 unit completes every third cycle
    for (int m = 0; m < 5; m++) begin
      hold_a[m] = 8'($urandom);
      hold_b[m] = 8'($urandom);
    end
    @(negedge clk);
    a_d = hold_a[0]; b_d = hold_b[0]; cin_d = 1'b0; sub_d = 1'b0; start_d = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        if (c < 3) begin
          check($sformatf("hold_done_low m=%0d c=%0d", m, c), 32'(done_v[1]), 32'd0);
        end else begin
          model(hold_a[m], hold_b[m], 1'b0, 1'b0, rs, rc, ro);
          check($sformatf("hold_done m=%0d", m), 32'(done_v[1]), 32'd1);
          check($sformatf("hold_s m=%0d", m), 32'(s_v[1]), 32'(rs));
          check($sformatf("hold_cout m=%0d", m), 32'(cout_v[1]), 32'(rc));
          a_d = hold_a[m+1];
          b_d = hold_b[m+1];
          prev_s[1] = rs;
        end
      end
    end
    start_d = 1'b0;
    repeat (12) @(negedge clk);
    prev_ok[0] = 1'b0;
    prev_ok[2] = 1'b0;

    // reset mid-RUN: asynchronous clear, then no done afterwards
    @(negedge clk);
    a_d = 8'h12; b_d = 8'h34; cin_d = 1'b0; sub_d = 1'b0; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state("midrun");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        check($sformatf("post_reset_done[%0d] c=%0d", i, c), 32'(done_v[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      prev_s[i]  = 8'h00;
      prev_ok[i] = 1'b1;
    end

    for (int n = 0; n < 30; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      model(ra, rb, rci, rsb, rs, rc, ro);
      run_op(ra, rb, rci, rsb, rs, rc, ro, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between digits. It replaces the single-cycle 4-bit ripple adder where wide operands or a short critical path are needed, and serves the datapath as a start/done coprocessor. It also provides subtract mode, carry-out and signed-overflow flags.

## Interface
- WIDTH, 32, operand/result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT is the digit count.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the unit is not busy.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; captured on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse: result valid.
- s  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1: latch the operands.
  - Latched B is b if sub=0, else ~b.
  - Carry flop is cin if sub=0, else ~cin.
  - Digit counter is cleared to 0 and the FSM goes to RUN.
- IDLE or DONE with start=0: go to or stay in IDLE.
- RUN: each edge adds digit i of A, B and the carry flop.
  - The DIGIT sum bits go into the internal result shift register, filling from LSB to MSB.
  - The carry flop takes the digit carry-out.
  - The counter increments.
  - On the edge processing digit N-1, go to DONE.
- start is ignored in RUN. No queueing; a, b, cin and sub may change freely.
- Arithmetic:
  - sub=0: {cout,s} = a + b + cin.
  - sub=1: s = a − b − cin (mod 2^WIDTH), computed as a + ~b + !cin; cout=1 means no borrow.
- overflow = (carry into bit WIDTH-1) XOR cout. Carry into the MSB is a[W-1] ^ b_eff[W-1] ^ s[W-1].
- s, cout and overflow are written only on the edge that processes digit N-1. They hold that value until the next completion; the previous result stays visible during RUN.
- busy = (state == RUN). done = (state == DONE).
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, s=0, cout=0, overflow=0, counter=0, carry flop=0.
- Reset mid-RUN aborts the operation: no done, outputs forced to reset values.

## Timing
- Let edge k be the edge that accepts start.
- busy=1 from after edge k through edge k+N. Digit i is processed at edge k+1+i.
- done=1 for exactly the cycle after edge k+N, with s, cout and overflow valid in that same cycle.
- Latency from the accepting edge to done is N+1 edges. Throughput is one operation per N+1 cycles when start is held high (DONE accepts start directly).
- DIGIT=WIDTH: N=1, one RUN cycle.
- start high in DONE is accepted at that edge: done drops and busy rises the next cycle.
- The counter needs ceil(log2(N)) bits, minimum 1. It wraps to 0 only on re-start; no wrap occurs inside RUN.

## Test plan
- WIDTH=8, DIGIT=4, a=8'hFF, b=8'h01, cin=0, sub=0, one start pulse -> busy for 2 cycles, then done=1 for 1 cycle with s=8'h00, cout=1, overflow=0.
- Same config, a=8'h7F, b=8'h01, cin=0, add -> s=8'h80, cout=0, overflow=1. Then a=8'h80, b=8'h80 -> s=8'h00, cout=1, overflow=1.
- Same config, sub=1, a=8'h05, b=8'h07, cin=0 -> s=8'hFE, cout=0. With cin=1 -> s=8'hFD. Then a=8'h80, b=8'h01, cin=0 -> s=8'h7F, overflow=1.
- start re-pulsed with new operands during RUN -> ignored; done arrives at the original time with the original result. start held high -> done every 3rd cycle and s updates each time.
- reset asserted mid-RUN (no clock edge needed) -> busy, done, s, cout and overflow go to 0 immediately; no done after release; a fresh start completes normally.
- WIDTH=8, DIGIT=1 and WIDTH=8, DIGIT=8, a=8'hA5, b=8'h5B, cin=1 -> s=8'h01, cout=1. Latency is 9 edges and 2 edges respectively from the accepting edge to done.
